// File: rtl/soc_sram_arbiter_pkg.sv
// rtl/soc_sram_arbiter_pkg.sv - shared types and constants for the SoC SRAM arbiter
package soc_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Byte address to 32-bit word address
  localparam int WORD_SHIFT = 2;

  // Width of a master index; never below one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soc_sram_arbiter_if.sv
// rtl/soc_sram_arbiter_if.sv - bundled request/response bus of all masters facing the arbiter
interface soc_sram_arbiter_if #(
  parameter int NUM_MASTERS = 2
);

  logic [32*NUM_MASTERS-1:0] i_m_adr;
  logic [32*NUM_MASTERS-1:0] i_m_dat;
  logic [4*NUM_MASTERS-1:0]  i_m_sel;
  logic [NUM_MASTERS-1:0]    i_m_we;
  logic [NUM_MASTERS-1:0]    i_m_cyc;
  logic [NUM_MASTERS-1:0]    o_m_ack;
  logic [NUM_MASTERS-1:0]    o_m_err;
  logic [31:0]               o_m_rdt;

  // Bus masters drive requests and receive ack/err/read data
  modport master (
    output i_m_adr, i_m_dat, i_m_sel, i_m_we, i_m_cyc,
    input  o_m_ack, o_m_err, o_m_rdt
  );

  // The arbiter consumes requests and returns responses
  modport slave (
    input  i_m_adr, i_m_dat, i_m_sel, i_m_we, i_m_cyc,
    output o_m_ack, o_m_err, o_m_rdt
  );

endinterface

// File: rtl/soc_sram_arbiter_rr_pick.sv
// rtl/soc_sram_arbiter_rr_pick.sv - combinational winner selection, round-robin or fixed priority
module soc_rr_pick
  import soc_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = idx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_grant,
  input  logic                   mode,
  output logic [NUM_MASTERS-1:0] win_onehot,
  output logic [IDX_W-1:0]       win_idx,
  output logic                   win_valid
);

  int             start_idx;
  logic [IDX_W-1:0] cand;

  // Scan from the start point and keep the first requesting index found
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    cand       = '0;
    if (mode == 1'(PRIO_FIXED)) begin
      start_idx = 0;
    end else begin
      start_idx = (int'(last_grant) + 1) % NUM_MASTERS;
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = IDX_W'((start_idx + i) % NUM_MASTERS);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
    if (win_valid) begin
      win_onehot[win_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/soc_sram_arbiter.sv
// rtl/soc_sram_arbiter.sv - N-master SRAM arbiter, registered grant held until ack; SOC_SRAM_ARB_TIMEOUT_EN adds BUSY timeout
module soc_sram_arbiter
  import soc_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 9,
  parameter int PRIO_MODE   = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              i_rst_n,
  soc_sram_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [31:0]       o_sram_wdata,
  output logic [3:0]        o_sram_wmask,
  output logic              o_sram_we,
  output logic              o_sram_cs,
  input  logic [31:0]       i_sram_rdata,
  input  logic              i_sram_ack
);

  localparam int IDX_W = idx_w(NUM_MASTERS);

  arb_state_e             state_q;
  logic [IDX_W-1:0]       grant_q;
  logic [NUM_MASTERS-1:0] grant_oh_q;
  logic [IDX_W-1:0]       last_q;

  logic [NUM_MASTERS-1:0] pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

  logic                   busy;
  logic                   done;
  logic                   abort;
  logic                   timeout;

  logic [ADDR_W-1:0]      adr_g;
  logic [31:0]            dat_g;
  logic [3:0]             sel_g;
  logic                   we_g;
  logic                   cyc_g;

  // Bits outside the word-address window are deliberately ignored
  logic                   adr_unused;
  assign adr_unused = ^bus.i_m_adr;

  soc_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .req        (bus.i_m_cyc),
    .last_grant (last_q),
    .mode       (1'(PRIO_MODE)),
    .win_onehot (pick_oh),
    .win_idx    (pick_idx),
    .win_valid  (pick_valid)
  );

  // Route the granted master's request fields
  always_comb begin
    adr_g = '0;
    dat_g = '0;
    sel_g = '0;
    we_g  = 1'b0;
    cyc_g = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q == IDX_W'(k)) begin
        adr_g = bus.i_m_adr[32*k+WORD_SHIFT +: ADDR_W];
        dat_g = bus.i_m_dat[32*k +: 32];
        sel_g = bus.i_m_sel[4*k +: 4];
        we_g  = bus.i_m_we[k];
        cyc_g = bus.i_m_cyc[k];
      end
    end
  end

  assign busy  = (state_q == ARB_BUSY);
  // An ack completes the transfer even if cyc drops in the same cycle
  assign done  = busy & i_sram_ack;
  assign abort = busy & ~cyc_g & ~i_sram_ack;

`ifdef SOC_SRAM_ARB_TIMEOUT_EN
  logic [7:0] tmo_q;

  // Count BUSY cycles without ack; held at zero while IDLE so each grant starts fresh
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_q <= '0;
    end else if (!busy) begin
      tmo_q <= '0;
    end else if (!i_sram_ack && (tmo_q != 8'hFF)) begin
      tmo_q <= tmo_q + 8'd1;
    end
  end

  assign timeout = busy & cyc_g & ~i_sram_ack & (tmo_q == 8'(TIMEOUT_CYC));
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  // Arbitration FSM: latch winner in IDLE, release on ack, abort or timeout
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      grant_oh_q <= '0;
      last_q     <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant_q    <= pick_idx;
            grant_oh_q <= pick_oh;
            state_q    <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (done || abort || timeout) begin
            last_q  <= grant_q;
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // SRAM side is quiet outside BUSY; cs follows the granted master's cyc
  assign o_sram_cs    = busy & cyc_g & ~timeout;
  assign o_sram_we    = busy & cyc_g & we_g & ~timeout;
  assign o_sram_addr  = busy ? adr_g : '0;
  assign o_sram_wdata = busy ? dat_g : '0;
  assign o_sram_wmask = busy ? sel_g : '0;

  assign bus.o_m_ack  = done    ? grant_oh_q : '0;
  assign bus.o_m_err  = timeout ? grant_oh_q : '0;
  assign bus.o_m_rdt  = i_sram_rdata;

endmodule

// File: tb/tb_soc_sram_arbiter.sv
// tb/tb_soc_sram_arbiter.sv - self-checking bench for soc_sram_arbiter (round-robin and fixed instances)
module tb_soc_sram_arbiter;
  import soc_arb_pkg::*;

  localparam int NM = 2;
  localparam int AW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [31:0]   rdata;
  logic          sack_rr, sack_fx;
  logic [AW-1:0] addr_rr, addr_fx;
  logic [31:0]   wdata_rr, wdata_fx;
  logic [3:0]    wmask_rr, wmask_fx;
  logic          we_rr, we_fx, cs_rr, cs_fx;

  soc_sram_arbiter_if #(.NUM_MASTERS(NM)) bus_rr ();
  soc_sram_arbiter_if #(.NUM_MASTERS(NM)) bus_fx ();

  soc_sram_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .PRIO_MODE(PRIO_RR), .TIMEOUT_CYC(5)) u_rr (
    .clk(clk), .i_rst_n(rst_n), .bus(bus_rr),
    .o_sram_addr(addr_rr), .o_sram_wdata(wdata_rr), .o_sram_wmask(wmask_rr),
    .o_sram_we(we_rr), .o_sram_cs(cs_rr), .i_sram_rdata(rdata), .i_sram_ack(sack_rr)
  );

  soc_sram_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .PRIO_MODE(PRIO_FIXED), .TIMEOUT_CYC(5)) u_fx (
    .clk(clk), .i_rst_n(rst_n), .bus(bus_fx),
    .o_sram_addr(addr_fx), .o_sram_wdata(wdata_fx), .o_sram_wmask(wmask_fx),
    .o_sram_we(we_fx), .o_sram_cs(cs_fx), .i_sram_rdata(rdata), .i_sram_ack(sack_fx)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arbitration: first requester from last+1 (round-robin) or from 0 (fixed)
  function automatic int model_pick(input logic [1:0] req, input int last, input bit fixed);
    for (int i = 0; i < NM; i++) begin
      int c;
      c = fixed ? i : (last + 1 + i) % NM;
      if (((req >> c) & 2'b01) != 2'b00) return c;
    end
    return -1;
  endfunction

  task automatic set_in(input bit fx, input logic [1:0] cyc, input logic sack);
    if (fx) begin
      bus_fx.i_m_cyc = cyc;
      sack_fx        = sack;
    end else begin
      bus_rr.i_m_cyc = cyc;
      sack_rr        = sack;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(1'b0, 2'b00, 1'b0);
    set_in(1'b1, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Both masters hold cyc and the SRAM acks every BUSY cycle; grants are scoreboarded
  task automatic run_sb(input bit fx, input string tag);
    int exp_q[$];
    int cnt_exp[NM];
    int cnt_got[NM];
    int mdl_last;
    int n_ack;
    int e;
    logic [1:0] ack;
    do_reset();
    mdl_last = NM - 1;
    for (int m = 0; m < NM; m++) begin
      cnt_exp[m] = 0;
      cnt_got[m] = 0;
    end
    @(posedge clk);
    #1;
    set_in(fx, 2'b11, 1'b1);
    for (int n = 0; n < 6; n++) begin
      e = model_pick(2'b11, mdl_last, fx);
      exp_q.push_back(e);
      cnt_exp[e]++;
      mdl_last = e;
    end
    n_ack = 0;
    for (int cyc = 0; cyc < 40 && n_ack < 6; cyc++) begin
      @(negedge clk);
      ack = fx ? bus_fx.o_m_ack : bus_rr.o_m_ack;
      if (ack != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk({tag, " extra ack"}, ack, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("%s grant %0d", tag, n_ack), ack, 64'(1 << e));
          for (int m = 0; m < NM; m++) if (ack[m]) cnt_got[m]++;
        end
        n_ack++;
      end
    end
    chk({tag, " pending expected"}, exp_q.size(), 0);
    for (int m = 0; m < NM; m++) chk($sformatf("%s acks m%0d", tag, m), cnt_got[m], cnt_exp[m]);
    @(posedge clk);
    #1;
    set_in(fx, 2'b00, 1'b0);
  endtask

  typedef struct packed {
    logic [1:0]  cyc;
    logic        sack;
    logic        exp_cs;
    logic        exp_we;
    logic [8:0]  exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
    logic [1:0]  exp_ack;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    int w;
    int bad_cyc;
    vec_t v;

    // idle, master 0 busy (read 0x10), master 1 busy (write 0x40)
    vecs[0]  = '{2'b00, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,         4'h0, 2'b00};
    vecs[1]  = '{2'b01, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,         4'h0, 2'b00};
    vecs[2]  = '{2'b01, 1'b0, 1'b1, 1'b0, 9'h004, 32'hA5A5A5A5, 4'hF, 2'b00};
    vecs[3]  = '{2'b01, 1'b1, 1'b1, 1'b0, 9'h004, 32'hA5A5A5A5, 4'hF, 2'b01};
    vecs[4]  = '{2'b00, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,         4'h0, 2'b00};
    vecs[5]  = '{2'b10, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,         4'h0, 2'b00};
    vecs[6]  = '{2'b10, 1'b0, 1'b1, 1'b1, 9'h010, 32'h12345678, 4'h3, 2'b00};
    vecs[7]  = '{2'b00, 1'b0, 1'b0, 1'b0, 9'h010, 32'h12345678, 4'h3, 2'b00};
    vecs[8]  = '{2'b00, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,         4'h0, 2'b00};
    vecs[9]  = '{2'b00, 1'b1, 1'b0, 1'b0, 9'h000, 32'h0,         4'h0, 2'b00};
    vecs[10] = '{2'b01, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,         4'h0, 2'b00};
    vecs[11] = '{2'b01, 1'b0, 1'b1, 1'b0, 9'h004, 32'hA5A5A5A5, 4'hF, 2'b00};
    vecs[12] = '{2'b00, 1'b1, 1'b0, 1'b0, 9'h004, 32'hA5A5A5A5, 4'hF, 2'b01};
    vecs[13] = '{2'b00, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,         4'h0, 2'b00};
    vecs[14] = '{2'b11, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,         4'h0, 2'b00};
    vecs[15] = '{2'b11, 1'b1, 1'b1, 1'b1, 9'h010, 32'h12345678, 4'h3, 2'b10};
    vecs[16] = '{2'b11, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,         4'h0, 2'b00};
    vecs[17] = '{2'b11, 1'b1, 1'b1, 1'b0, 9'h004, 32'hA5A5A5A5, 4'hF, 2'b01};
    vecs[18] = '{2'b00, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,         4'h0, 2'b00};

    rst_n = 1'b0;
    rdata = 32'hDEADBEEF;
    bus_rr.i_m_adr = {32'h0000_0040, 32'h0000_0010};
    bus_rr.i_m_dat = {32'h1234_5678, 32'hA5A5_A5A5};
    bus_rr.i_m_sel = {4'b0011, 4'b1111};
    bus_rr.i_m_we  = 2'b10;
    bus_fx.i_m_adr = {32'h0000_0040, 32'h0000_0010};
    bus_fx.i_m_dat = {32'h1234_5678, 32'hA5A5_A5A5};
    bus_fx.i_m_sel = {4'b0011, 4'b1111};
    bus_fx.i_m_we  = 2'b10;
    set_in(1'b0, 2'b01, 1'b1);
    set_in(1'b1, 2'b00, 1'b0);

    // Reset state, with a request and SRAM ack present to show they are ignored
    #2;
    chk("reset cs", cs_rr, 0);
    chk("reset we", we_rr, 0);
    chk("reset addr", addr_rr, 0);
    chk("reset wdata", wdata_rr, 0);
    chk("reset ack", bus_rr.o_m_ack, 0);
    chk("reset err", bus_rr.o_m_err, 0);
    @(negedge clk);
    @(negedge clk);
    set_in(1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;

    // Table-driven single-transfer, abort and back-to-back sequences
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(posedge clk);
      #1;
      set_in(1'b0, v.cyc, v.sack);
      @(negedge clk);
      chk($sformatf("v%0d cs", i), cs_rr, v.exp_cs);
      chk($sformatf("v%0d we", i), we_rr, v.exp_we);
      chk($sformatf("v%0d addr", i), addr_rr, v.exp_addr);
      chk($sformatf("v%0d wdata", i), wdata_rr, v.exp_wdata);
      chk($sformatf("v%0d wmask", i), wmask_rr, v.exp_wmask);
      chk($sformatf("v%0d ack", i), bus_rr.o_m_ack, v.exp_ack);
      chk($sformatf("v%0d err", i), bus_rr.o_m_err, 0);
      chk($sformatf("v%0d rdt", i), bus_rr.o_m_rdt, 32'hDEADBEEF);
    end

    run_sb(1'b0, "rr");
    run_sb(1'b1, "fixed");

    // Reset asserted mid-transfer drops cs without a clock edge
    do_reset();
    @(posedge clk);
    #1;
    set_in(1'b0, 2'b01, 1'b0);
    for (int c = 0; c < 5 && cs_rr !== 1'b1; c++) @(negedge clk);
    chk("mid-rst busy cs", cs_rr, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid-rst async cs", cs_rr, 0);
    chk("mid-rst ack", bus_rr.o_m_ack, 0);
    set_in(1'b0, 2'b11, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    w = model_pick(2'b11, NM - 1, 1'b0);
    @(negedge clk);
    chk("post-rst cs", cs_rr, 1);
    chk("post-rst addr", addr_rr, (w == 0) ? 9'h004 : 9'h010);
    @(posedge clk);
    #1;
    sack_rr = 1'b1;
    @(negedge clk);
    chk("post-rst ack", bus_rr.o_m_ack, 64'(1 << w));
    @(posedge clk);
    #1;
    set_in(1'b0, 2'b00, 1'b0);

    // SRAM never acks: timeout behaviour depends on the build
    do_reset();
    @(posedge clk);
    #1;
    set_in(1'b0, 2'b11, 1'b0);
    @(negedge clk);
    bad_cyc = 0;
`ifdef SOC_SRAM_ARB_TIMEOUT_EN
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (cs_rr !== 1'b1 || bus_rr.o_m_err !== 2'b00) bad_cyc++;
    end
    chk("tmo wait cycles", bad_cyc, 0);
    @(negedge clk);
    chk("tmo err pulse", bus_rr.o_m_err, 2'b01);
    chk("tmo no ack", bus_rr.o_m_ack, 0);
    @(negedge clk);
    chk("tmo err single", bus_rr.o_m_err, 0);
    @(negedge clk);
    chk("tmo next cs", cs_rr, 1);
    chk("tmo next addr", addr_rr, 9'h010);
`else
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (cs_rr !== 1'b1 || addr_rr !== 9'h004 || bus_rr.o_m_err !== 2'b00) bad_cyc++;
    end
    chk("no-tmo cs held", bad_cyc, 0);
`endif
    set_in(1'b0, 2'b00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
